// File: rtl/shift4_deserializer.sv
// Serial-in/parallel-out receiver: shifts WIDTH bits in LSB first and presents each word on a valid/ready holding register.
// Optional even-parity check per word is enabled by defining SHIFT4_DESER_PARITY_EN.
module shift4_deserializer #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             ena,
    input  logic             sin,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SHIFT4_DESER_PARITY_EN
    typedef enum logic [0:0] {
        ST_SHIFT  = 1'b0,
        ST_PARITY = 1'b1
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_SHIFT = 1'b0
    } state_e;
`endif

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] sreg_q,       sreg_d;
    logic [CW-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q,    overrun_d;
    logic             parity_err_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             deliver;

    assign shifted = {sin, sreg_q[WIDTH-1:1]};

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        parity_err_d = 1'b0;
        deliver      = 1'b0;
        word         = shifted;

        // The consumer handshake is independent of clear and of delivery.
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (clear) begin
            // clear wins over ena: the bit arriving on this edge is discarded.
            state_d   = ST_SHIFT;
            sreg_d    = '0;
            bit_cnt_d = '0;
            overrun_d = 1'b0;
        end else if (ena) begin
            case (state_q)
`ifdef SHIFT4_DESER_PARITY_EN
                ST_PARITY: begin
                    // sreg holds the complete data word; sin is its parity bit.
                    state_d = ST_SHIFT;
                    if (^{sreg_q, sin}) begin
                        parity_err_d = 1'b1;
                    end else begin
                        deliver = 1'b1;
                        word    = sreg_q;
                    end
                end
`endif
                default: begin
                    sreg_d = shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SHIFT4_DESER_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        deliver   = 1'b1;
                        word      = shifted;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            endcase
        end

        // A full holding register that is not being drained drops the new word.
        if (deliver) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_SHIFT;
            sreg_q       <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SHIFT4_DESER_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_err_d;
    assign parity_err    = 1'b0;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign bit_cnt    = bit_cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift4_deserializer.sv
// Directed bench for shift4_deserializer at WIDTH=4; parity scenario runs only when SHIFT4_DESER_PARITY_EN is defined.
module tb_shift4_deserializer;

    logic       clk = 1'b0;
    logic       areset;
    logic       ena;
    logic       sin;
    logic       clear;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [1:0] bit_cnt;
    logic       overrun;
    logic       parity_err;

    int vectors     = 0;
    int miscompares = 0;

    shift4_deserializer #(.WIDTH(4)) dut (
        .clk        (clk),
        .areset     (areset),
        .ena        (ena),
        .sin        (sin),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic send_bit(input logic b);
        ena = 1'b1;
        sin = b;
        @(posedge clk);
        #1;
        ena = 1'b0;
        sin = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
    endtask

    task automatic test_reset;
        areset = 1'b1; ena = 1'b0; sin = 1'b0; clear = 1'b0; dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
        vectors++;
        if ({dout, dout_valid, bit_cnt, overrun, parity_err} !== 9'b0000_0_00_0_0) begin
            $display("FAIL reset_values: got dout=%h valid=%b cnt=%0d ovr=%b perr=%b, want all 0",
                     dout, dout_valid, bit_cnt, overrun, parity_err);
            miscompares++;
        end
    endtask

    task automatic test_basic;
        logic [3:0] bits;
        logic [1:0] exp_cnt [4];
        bits = 4'b1101;
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i]);
            vectors++;
            if (bit_cnt !== exp_cnt[i]) begin
                $display("FAIL basic_bit_cnt[%0d]: got %0d want %0d", i, bit_cnt, exp_cnt[i]);
                miscompares++;
            end
        end
        vectors++;
        if (dout !== 4'hD || dout_valid !== 1'b1 || parity_err !== 1'b0) begin
            $display("FAIL basic_word: got dout=%h valid=%b perr=%b want D 1 0", dout, dout_valid, parity_err);
            miscompares++;
        end
        idle(2);
        vectors++;
        if (dout !== 4'hD || dout_valid !== 1'b1) begin
            $display("FAIL basic_hold: got dout=%h valid=%b want D 1", dout, dout_valid);
            miscompares++;
        end
        drain();
        vectors++;
        if (dout_valid !== 1'b0 || dout !== 4'hD) begin
            $display("FAIL basic_drain: got dout=%h valid=%b want D 0", dout, dout_valid);
            miscompares++;
        end
    endtask

    task automatic test_gapped;
        logic [3:0] bits;
        bits = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            send_bit(bits[i]);
            idle(2);
            vectors++;
            if (bit_cnt !== 2'(i + 1) || dout_valid !== 1'b0) begin
                $display("FAIL gap_hold[%0d]: got cnt=%0d valid=%b want %0d 0", i, bit_cnt, dout_valid, i + 1);
                miscompares++;
            end
        end
        send_bit(bits[3]);
        vectors++;
        if (dout !== 4'hD || dout_valid !== 1'b1 || bit_cnt !== 2'd0) begin
            $display("FAIL gap_word: got dout=%h valid=%b cnt=%0d want D 1 0", dout, dout_valid, bit_cnt);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_back_to_back;
        logic [3:0] w1;
        logic [3:0] w2;
        w1 = 4'hD;
        w2 = 4'h6;
        for (int i = 0; i < 4; i++) send_bit(w1[i]);
        for (int i = 0; i < 3; i++) send_bit(w2[i]);
        vectors++;
        if (dout !== 4'hD || dout_valid !== 1'b1) begin
            $display("FAIL b2b_first_held: got dout=%h valid=%b want D 1", dout, dout_valid);
            miscompares++;
        end
        dout_ready = 1'b1;
        send_bit(w2[3]);
        dout_ready = 1'b0;
        vectors++;
        if (dout !== 4'h6 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
            $display("FAIL b2b_second: got dout=%h valid=%b ovr=%b want 6 1 0", dout, dout_valid, overrun);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_overrun_clear;
        logic [3:0] w1;
        logic [3:0] w2;
        w1 = 4'hA;
        w2 = 4'h5;
        for (int i = 0; i < 4; i++) send_bit(w1[i]);
        for (int i = 0; i < 4; i++) send_bit(w2[i]);
        vectors++;
        if (dout !== 4'hA || dout_valid !== 1'b1 || overrun !== 1'b1) begin
            $display("FAIL overrun_set: got dout=%h valid=%b ovr=%b want A 1 1", dout, dout_valid, overrun);
            miscompares++;
        end
        send_bit(1'b1);
        send_bit(1'b1);
        vectors++;
        if (bit_cnt !== 2'd2 || overrun !== 1'b1) begin
            $display("FAIL overrun_sticky: got cnt=%0d ovr=%b want 2 1", bit_cnt, overrun);
            miscompares++;
        end
        clear = 1'b1;
        send_bit(1'b1);
        clear = 1'b0;
        vectors++;
        if (bit_cnt !== 2'd0 || overrun !== 1'b0 || dout_valid !== 1'b1 || dout !== 4'hA) begin
            $display("FAIL clear: got cnt=%0d ovr=%b valid=%b dout=%h want 0 0 1 A",
                     bit_cnt, overrun, dout_valid, dout);
            miscompares++;
        end
        clear = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        dout_ready = 1'b0;
        vectors++;
        if (dout_valid !== 1'b0) begin
            $display("FAIL clear_with_handshake: got valid=%b want 0", dout_valid);
            miscompares++;
        end
        // Discarded partial word: a fresh word after clear must assemble cleanly.
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        vectors++;
        if (dout !== 4'hC || dout_valid !== 1'b1) begin
            $display("FAIL after_clear_word: got dout=%h valid=%b want C 1", dout, dout_valid);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_reset_midword;
        logic [3:0] w;
        w = 4'h9;
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        send_bit(1'b1);
        send_bit(1'b0);
        vectors++;
        if (dout !== 4'h9 || dout_valid !== 1'b1 || bit_cnt !== 2'd2) begin
            $display("FAIL pre_reset: got dout=%h valid=%b cnt=%0d want 9 1 2", dout, dout_valid, bit_cnt);
            miscompares++;
        end
        #2;
        areset = 1'b1;
        #1;
        vectors++;
        if (dout !== 4'h0 || dout_valid !== 1'b0 || bit_cnt !== 2'd0 || overrun !== 1'b0) begin
            $display("FAIL async_reset: got dout=%h valid=%b cnt=%0d ovr=%b want 0 0 0 0",
                     dout, dout_valid, bit_cnt, overrun);
            miscompares++;
        end
        @(posedge clk);
        #1;
        areset = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        vectors++;
        if (dout !== 4'h7 || dout_valid !== 1'b1) begin
            $display("FAIL post_reset_word: got dout=%h valid=%b want 7 1", dout, dout_valid);
            miscompares++;
        end
        drain();
    endtask

`ifdef SHIFT4_DESER_PARITY_EN
    task automatic test_parity;
        logic [3:0] w;
        w = 4'hD;
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        vectors++;
        if (dout_valid !== 1'b0 || bit_cnt !== 2'd0) begin
            $display("FAIL parity_wait: got valid=%b cnt=%0d want 0 0", dout_valid, bit_cnt);
            miscompares++;
        end
        send_bit(1'b1);
        vectors++;
        if (dout !== 4'hD || dout_valid !== 1'b1 || parity_err !== 1'b0) begin
            $display("FAIL parity_good: got dout=%h valid=%b perr=%b want D 1 0", dout, dout_valid, parity_err);
            miscompares++;
        end
        drain();
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        send_bit(1'b0);
        vectors++;
        if (parity_err !== 1'b1 || dout_valid !== 1'b0) begin
            $display("FAIL parity_bad: got perr=%b valid=%b want 1 0", parity_err, dout_valid);
            miscompares++;
        end
        idle(1);
        vectors++;
        if (parity_err !== 1'b0 || dout_valid !== 1'b0) begin
            $display("FAIL parity_pulse: got perr=%b valid=%b want 0 0", parity_err, dout_valid);
            miscompares++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_overrun_clear();
        test_reset_midword();
`ifdef SHIFT4_DESER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
